player_input_conditioner: RTL and testbench



---
 rtl/player_input_conditioner_pkg.sv | 15 +
 rtl/player_input_conditioner_button_debouncer.sv | 60 ++++++
 rtl/player_input_conditioner.sv | 77 +++++++
 tb/tb_player_input_conditioner.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/player_input_conditioner_pkg.sv
// rtl/player_input_conditioner_pkg.sv - shared button FSM encoding for the input conditioner
package player_input_conditioner_pkg;

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] WAIT_PRESS = 3'd1;
  localparam logic [2:0] PULSE      = 3'd2;
  localparam logic [2:0] HELD       = 3'd3;
  localparam logic [2:0] WAIT_REL   = 3'd4;

  // A button counts as debounced-pressed from its pulse until release is accepted.
  function automatic logic is_held(logic [2:0] st);
    return (st == PULSE) || (st == HELD) || (st == WAIT_REL);
  endfunction

endpackage

// File: rtl/player_input_conditioner_button_debouncer.sv
// rtl/player_input_conditioner_button_debouncer.sv - synchronizer plus press/release debounce FSM for one button
module button_debouncer
  import player_input_conditioner_pkg::*;
#(
  parameter int DEB_W = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic pulse,
  output logic held
);

  logic [1:0]       sync_q;
  logic             sync_in;
  logic [2:0]       state;
  logic [DEB_W-1:0] cnt;

  assign sync_in = sync_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 2'b00;
    else     sync_q <= {sync_q[0], raw};
  end

  // Counter only restarts on entry to a waiting state, so it never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (sync_in) begin
          state <= WAIT_PRESS;
          cnt   <= '0;
        end
        WAIT_PRESS: begin
          if (!sync_in)  state <= IDLE;
          else if (&cnt) state <= PULSE;
          else           cnt   <= cnt + DEB_W'(1);
        end
        PULSE: state <= HELD;
        HELD: if (!sync_in) begin
          state <= WAIT_REL;
          cnt   <= '0;
        end
        WAIT_REL: begin
          if (sync_in)   state <= HELD;
          else if (&cnt) state <= IDLE;
          else           cnt   <= cnt + DEB_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign pulse = (state == PULSE);
  assign held  = is_held(state);

endmodule

// File: rtl/player_input_conditioner.sv
// rtl/player_input_conditioner.sv - debounced button pulses and stable switch words for the game core
module player_input_conditioner
  import player_input_conditioner_pkg::*;
#(
  parameter int DEB_W   = 20,
  parameter int SW_W    = 16,
  parameter int SW_BITS = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_left_raw,
  input  logic               btn_right_raw,
  input  logic [SW_BITS-1:0] swA_raw,
  input  logic [SW_BITS-1:0] swB_raw,
  output logic               left_pulse,
  output logic               right_pulse,
  output logic               left_held,
  output logic               right_held,
  output logic [SW_BITS-1:0] Ain,
  output logic [SW_BITS-1:0] Bin
);

  button_debouncer #(.DEB_W(DEB_W)) u_left (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_left_raw),
    .pulse (left_pulse),
    .held  (left_held)
  );

  button_debouncer #(.DEB_W(DEB_W)) u_right (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_right_raw),
    .pulse (right_pulse),
    .held  (right_held)
  );

  logic [SW_BITS-1:0] sw_raw [2];
  logic [SW_BITS-1:0] sw_out [2];

  assign sw_raw[0] = swA_raw;
  assign sw_raw[1] = swB_raw;

  // Any bit change restarts the stability count; the word is only published once saturated.
  for (genvar p = 0; p < 2; p++) begin : g_sw
    logic [SW_BITS-1:0] s1, s2, cand, word;
    logic [SW_W-1:0]    scnt;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s1   <= '0;
        s2   <= '0;
        cand <= '0;
        scnt <= '0;
        word <= '0;
      end else begin
        s1 <= sw_raw[p];
        s2 <= s1;
        if (s2 != cand) begin
          cand <= s2;
          scnt <= '0;
        end else if (!(&scnt)) begin
          scnt <= scnt + SW_W'(1);
        end else begin
          word <= cand;
        end
      end
    end

    assign sw_out[p] = word;
  end

  assign Ain = sw_out[0];
  assign Bin = sw_out[1];

endmodule

// File: tb/tb_player_input_conditioner.sv
// tb/tb_player_input_conditioner.sv - randomized and directed checks of the input conditioner against a run-length model
module tb_player_input_conditioner;

  localparam int DEB_W   = 2;
  localparam int SW_W    = 2;
  localparam int SW_BITS = 8;
  localparam int BTN_RUN = (1 << DEB_W) + 1;
  localparam int SW_RUN  = (1 << SW_W) + 1;

  logic               clk;
  logic               rst;
  logic               btn_left_raw, btn_right_raw;
  logic [SW_BITS-1:0] swA_raw, swB_raw;
  logic               left_pulse, right_pulse, left_held, right_held;
  logic [SW_BITS-1:0] Ain, Bin;

  player_input_conditioner #(.DEB_W(DEB_W), .SW_W(SW_W), .SW_BITS(SW_BITS)) dut (
    .clk           (clk),
    .rst           (rst),
    .btn_left_raw  (btn_left_raw),
    .btn_right_raw (btn_right_raw),
    .swA_raw       (swA_raw),
    .swB_raw       (swB_raw),
    .left_pulse    (left_pulse),
    .right_pulse   (right_pulse),
    .left_held     (left_held),
    .right_held    (right_held),
    .Ain           (Ain),
    .Bin           (Bin)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Model: inputs are seen two edges late; a level is accepted after BTN_RUN/SW_RUN consecutive observations.
  bit                 b_p1 [2], b_p2 [2], b_down [2], b_pulse [2], b_skip [2];
  int                 b_run [2];
  logic [SW_BITS-1:0] w_p1 [2], w_p2 [2], w_word [2], w_out [2];
  int                 w_run [2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      b_p1[i] = 0; b_p2[i] = 0; b_down[i] = 0; b_pulse[i] = 0; b_skip[i] = 0; b_run[i] = 0;
      w_p1[i] = '0; w_p2[i] = '0; w_word[i] = '0; w_out[i] = '0; w_run[i] = 1;
    end
  endtask

  task automatic model_step();
    bit                 raw_b [2];
    logic [SW_BITS-1:0] raw_w [2];
    bit                 ob;
    logic [SW_BITS-1:0] ow;
    raw_b[0] = btn_left_raw; raw_b[1] = btn_right_raw;
    raw_w[0] = swA_raw;      raw_w[1] = swB_raw;
    for (int i = 0; i < 2; i++) begin
      ob = b_p2[i];
      b_p2[i] = b_p1[i];
      b_p1[i] = raw_b[i];
      if (b_skip[i]) begin
        b_skip[i]  = 0;
        b_pulse[i] = 0;
      end else begin
        if (ob != b_down[i]) b_run[i]++;
        else                 b_run[i] = 0;
        if (b_run[i] == BTN_RUN) begin
          b_run[i]  = 0;
          b_down[i] = !b_down[i];
          if (b_down[i]) begin
            b_pulse[i] = 1;
            b_skip[i]  = 1;
          end
        end
      end
      ow = w_p2[i];
      w_p2[i] = w_p1[i];
      w_p1[i] = raw_w[i];
      if (ow != w_word[i]) begin
        w_word[i] = ow;
        w_run[i]  = 1;
      end else if (w_run[i] < SW_RUN) begin
        w_run[i]++;
      end
      if (w_run[i] >= SW_RUN) w_out[i] = w_word[i];
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else     model_step();
  end

  always @(negedge clk) begin
    logic [19:0] act, exp;
    if (!rst) begin
      act = {left_pulse, right_pulse, left_held, right_held, Ain, Bin};
      exp = {b_pulse[0], b_pulse[1], b_down[0], b_down[1], w_out[0], w_out[1]};
      n_tests++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL model cyc=%0d lp/rp/lh/rh/A/B got %b %b %b %b %h %h want %b %b %b %b %h %h",
                 cyc, act[19], act[18], act[17], act[16], act[15:8], act[7:0],
                 exp[19], exp[18], exp[17], exp[16], exp[15:8], exp[7:0]);
      end
    end
  end

  int lp_cnt = 0, rp_cnt = 0, lp_edge = -1, rp_edge = -1, lh_cnt = 0, lh_fall = -1, cnt_3c = 0;
  logic lh_prev = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (left_pulse)  begin lp_cnt++; lp_edge = cyc; end
      if (right_pulse) begin rp_cnt++; rp_edge = cyc; end
      if (left_held) lh_cnt++;
      if (lh_prev && !left_held) lh_fall = cyc;
      if (Ain == 8'h3C) cnt_3c++;
    end
    lh_prev = left_held;
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    int e, lb, rb, hb, c3;
    int bl [2];
    int sl [2];
    rst = 1'b0;
    btn_left_raw = 0; btn_right_raw = 0; swA_raw = '0; swB_raw = '0;
    #1 rst = 1'b1;
    #2 check("reset_outputs", {left_pulse, right_pulse, left_held, right_held, Ain, Bin}, 0);
    step(3);
    #1 rst = 1'b0;
    step(4);

    // clean press
    lb = lp_cnt; rb = rp_cnt; e = cyc;
    btn_left_raw = 1;
    step(20);
    check("press_pulse_count", lp_cnt - lb, 1);
    check("press_pulse_edge", lp_edge - e, 7);
    check("press_held", left_held, 1);
    check("press_right_quiet", rp_cnt - rb, 0);
    btn_left_raw = 0;
    step(12);

    // press glitch
    lb = lp_cnt; hb = lh_cnt;
    btn_left_raw = 1;
    step(3);
    btn_left_raw = 0;
    step(15);
    check("glitch_no_pulse", lp_cnt - lb, 0);
    check("glitch_no_held", lh_cnt - hb, 0);

    // release bounce
    lb = lp_cnt;
    btn_left_raw = 1;
    step(20);
    btn_left_raw = 0; step(1);
    btn_left_raw = 1; step(1);
    btn_left_raw = 0; step(1);
    btn_left_raw = 1; step(1);
    btn_left_raw = 0; e = cyc;
    step(12);
    check("bounce_one_pulse", lp_cnt - lb, 1);
    check("bounce_held_fall", lh_fall - e, 7);

    // simultaneous
    lb = lp_cnt; rb = rp_cnt; e = cyc;
    btn_left_raw = 1; btn_right_raw = 1;
    step(20);
    check("simul_left_count", lp_cnt - lb, 1);
    check("simul_right_count", rp_cnt - rb, 1);
    check("simul_same_edge", lp_edge, rp_edge);
    check("simul_edge", lp_edge - e, 7);
    btn_left_raw = 0; btn_right_raw = 0;
    step(12);

    // switch stability
    swA_raw = 8'h5A;
    step(8);
    check("sw_clean_update", Ain, 8'h5A);
    c3 = cnt_3c;
    swA_raw = 8'h3C;
    step(2);
    swA_raw = 8'h5A;
    step(12);
    check("sw_short_word_hold", Ain, 8'h5A);
    check("sw_short_word_hidden", cnt_3c - c3, 0);

    // reset mid-operation
    btn_left_raw = 1;
    step(4);
    #1 rst = 1'b1;
    #1 check("midreset_outputs", {left_pulse, right_pulse, left_held, right_held, Ain, Bin}, 0);
    step(1);
    lb = lp_cnt;
    #1 rst = 1'b0;
    e = cyc;
    step(20);
    check("midreset_one_pulse", lp_cnt - lb, 1);
    check("midreset_pulse_edge", lp_edge - e, 7);
    check("midreset_ain_back", Ain, 8'h5A);
    btn_left_raw = 0;
    step(12);

    // randomized phase, checked every cycle against the model
    bl[0] = 1; bl[1] = 1; sl[0] = 1; sl[1] = 1;
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < 2; i++) begin
        bl[i]--;
        if (bl[i] == 0) begin
          if (i == 0) btn_left_raw  = ~btn_left_raw;
          else        btn_right_raw = ~btn_right_raw;
          bl[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : int'($urandom_range(5, 14));
        end
        sl[i]--;
        if (sl[i] == 0) begin
          if (i == 0) swA_raw = SW_BITS'($urandom);
          else        swB_raw = SW_BITS'($urandom);
          sl[i] = int'($urandom_range(1, 9));
        end
      end
      step(1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
